// File: rtl/m_uartrx_pkg.sv
// m_uartrx_pkg: shared constants for the Wishbone UART receiver.
//   - FSM state encoding (legacy 3-bit constants)
//   - register offsets selected by ADR_I
//   - STATUS register bit positions
package m_uartrx_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    localparam int SB_NE   = 0;
    localparam int SB_FULL = 1;
    localparam int SB_OVR  = 2;
    localparam int SB_FERR = 3;
    localparam int SB_PERR = 4;
    localparam int SB_CNT  = 5;   // 4-bit count field at [8:5]

endpackage

// File: rtl/m_uartrx_fifo.sv
// m_uartrx_fifo: synchronous byte FIFO, depth 2**FIFOAW.
//   CLK_I, RST_In : clock, async active-low reset
//   push, din     : write request and byte (ignored when full)
//   pop           : read request (ignored when empty)
//   head          : byte at the read pointer
//   count         : occupancy, FIFOAW+1 bits
//   full, empty   : occupancy flags
module m_uartrx_fifo #(
    parameter int FIFOAW = 2
) (
    input  logic            CLK_I,
    input  logic            RST_In,
    input  logic            push,
    input  logic [7:0]      din,
    input  logic            pop,
    output logic [7:0]      head,
    output logic [FIFOAW:0] count,
    output logic            full,
    output logic            empty
);

    localparam logic [FIFOAW:0] DEPTH = {1'b1, {FIFOAW{1'b0}}};

    logic [7:0]        mem [2**FIFOAW];
    logic [FIFOAW-1:0] wp, rp;
    logic              do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign head    = mem[rp];

    always_ff @(posedge CLK_I or negedge RST_In) begin
        if (!RST_In) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            // simultaneous push and pop leave the count alone
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK_I) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/m_uartrx_wb.sv
// m_uartrx_wb: UART receiver (8N1, or 8E1 with M_UARTRX_PARITY_EN defined)
// behind a Wishbone classic responder port.
//   CLK_I, RST_In : clock, async active-low reset
//   usartRX       : asynchronous serial input, idle high
//   STB_I, WE_I   : decoded strobe, write enable
//   ADR_I         : 0 = DATA, 1 = STATUS
//   DAT_I         : write data, [4:2] = W1C for OVR/FERR/PERR
//   ACK_O, DAT_O  : registered one-cycle acknowledge and read data
//   rxirq         : FIFO not empty
// Optional feature macro: M_UARTRX_PARITY_EN (even parity bit before stop).
module m_uartrx_wb
    import m_uartrx_pkg::*;
#(
    parameter int CLKDIV = 104,
    parameter int FIFOAW = 2
) (
    input  logic        CLK_I,
    input  logic        RST_In,
    input  logic        usartRX,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic        ADR_I,
    input  logic [31:0] DAT_I,
    output logic        ACK_O,
    output logic [31:0] DAT_O,
    output logic        rxirq
);

    localparam int            CW    = $clog2(CLKDIV);
    localparam logic [CW-1:0] FULLC = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] HALFC = CW'(CLKDIV / 2 - 1);

    logic            rx1, rxs;
    logic [2:0]      state;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      sh;
    logic            tick, stop_ev, bad;
    logic            push, pop, full, empty;
    logic [7:0]      head;
    logic [FIFOAW:0] count;
    logic            ovr, ferr, perr;
    logic            ovr_set, ferr_set, perr_set;
    logic            acc, clr_wr;
    logic [31:0]     rd_data;
    logic            unused_dat;

    assign unused_dat = ^{DAT_I[31:5], DAT_I[1:0]};

    // two-flop synchroniser, idles high so reset does not look like a start bit
    always_ff @(posedge CLK_I or negedge RST_In) begin
        if (!RST_In) begin
            rx1 <= 1'b1;
            rxs <= 1'b1;
        end else begin
            rx1 <= usartRX;
            rxs <= rx1;
        end
    end

    assign tick = (cnt == '0);

    always_ff @(posedge CLK_I or negedge RST_In) begin
        if (!RST_In) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (!rxs) begin
                    state <= ST_START;
                    cnt   <= HALFC;
                end
                ST_START: if (tick) begin
                    // still low at mid-bit: a real start bit, otherwise a glitch
                    state <= rxs ? ST_IDLE : ST_DATA;
                    cnt   <= FULLC;
                    idx   <= '0;
                end else cnt <= cnt - 1'b1;
                ST_DATA: if (tick) begin
                    sh  <= {rxs, sh[7:1]};
                    cnt <= FULLC;
                    idx <= idx + 1'b1;
`ifdef M_UARTRX_PARITY_EN
                    if (idx == 3'd7) state <= ST_PAR;
`else
                    if (idx == 3'd7) state <= ST_STOP;
`endif
                end else cnt <= cnt - 1'b1;
`ifdef M_UARTRX_PARITY_EN
                ST_PAR: if (tick) begin
                    state <= ST_STOP;
                    cnt   <= FULLC;
                end else cnt <= cnt - 1'b1;
`endif
                ST_STOP: if (tick) state <= ST_IDLE;
                         else      cnt   <= cnt - 1'b1;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef M_UARTRX_PARITY_EN
    // a parity miss poisons the frame; STOP then neither pushes nor flags
    assign perr_set = (state == ST_PAR) & tick & (rxs != ^sh);

    always_ff @(posedge CLK_I or negedge RST_In) begin
        if (!RST_In) begin
            bad  <= 1'b0;
            perr <= 1'b0;
        end else begin
            if (perr_set)     bad <= 1'b1;
            else if (stop_ev) bad <= 1'b0;
            perr <= perr_set | (perr & ~(clr_wr & DAT_I[4]));
        end
    end
`else
    assign perr_set = 1'b0;
    assign bad      = 1'b0;
    assign perr     = 1'b0;
`endif

    assign stop_ev  = (state == ST_STOP) & tick;
    assign push     = stop_ev & rxs & ~bad & ~full;
    assign ovr_set  = stop_ev & rxs & ~bad & full;
    assign ferr_set = stop_ev & ~rxs & ~bad;

    // acc is the cycle on whose closing edge ACK_O rises
    assign acc    = STB_I & ~ACK_O;
    assign clr_wr = acc & WE_I & (ADR_I == REG_STATUS);
    assign pop    = acc & ~WE_I & (ADR_I == REG_DATA) & ~empty;

    // set wins over a coincident clear
    always_ff @(posedge CLK_I or negedge RST_In) begin
        if (!RST_In) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovr  <= ovr_set  | (ovr  & ~(clr_wr & DAT_I[2]));
            ferr <= ferr_set | (ferr & ~(clr_wr & DAT_I[3]));
        end
    end

    m_uartrx_fifo #(.FIFOAW(FIFOAW)) u_fifo (
        .CLK_I  (CLK_I),
        .RST_In (RST_In),
        .push   (push),
        .din    (sh),
        .pop    (pop),
        .head   (head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always_comb begin
        rd_data = '0;
        if (!WE_I) begin
            if (ADR_I == REG_DATA) begin
                rd_data[7:0] = empty ? 8'h00 : head;
                rd_data[8]   = ~empty;
            end else begin
                rd_data[SB_NE]          = ~empty;
                rd_data[SB_FULL]        = full;
                rd_data[SB_OVR]         = ovr;
                rd_data[SB_FERR]        = ferr;
                rd_data[SB_PERR]        = perr;
                rd_data[SB_CNT +: 4]    = 4'(count);
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RST_In) begin
        if (!RST_In) begin
            ACK_O <= 1'b0;
            DAT_O <= '0;
        end else begin
            ACK_O <= acc;
            if (acc) DAT_O <= rd_data;
        end
    end

    assign rxirq = ~empty;

endmodule

// File: tb/tb_m_uartrx_wb.sv
// tb_m_uartrx_wb: directed bench for m_uartrx_wb with CLKDIV=8, FIFOAW=2.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_m_uartrx_wb;

    logic        CLK_I = 1'b0;
    logic        RST_In;
    logic        usartRX;
    logic        STB_I, WE_I, ADR_I;
    logic [31:0] DAT_I;
    logic        ACK_O;
    logic [31:0] DAT_O;
    logic        rxirq;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] rd, rd2;

    m_uartrx_wb #(.CLKDIV(8), .FIFOAW(2)) dut (
        .CLK_I   (CLK_I),
        .RST_In  (RST_In),
        .usartRX (usartRX),
        .STB_I   (STB_I),
        .WE_I    (WE_I),
        .ADR_I   (ADR_I),
        .DAT_I   (DAT_I),
        .ACK_O   (ACK_O),
        .DAT_O   (DAT_O),
        .rxirq   (rxirq)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // drive the first nslots bit slots (start, d0..d7, stop) of a frame
    task automatic send_bits(input logic [7:0] b, input logic stopb, input int nslots);
        logic [9:0] fr;
        fr = {stopb, b, 1'b0};
        for (int i = 0; i < nslots; i++) begin
            usartRX = fr[i];
            repeat (8) @(negedge CLK_I);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stopb);
        send_bits(b, stopb, 10);
        usartRX = 1'b1;
        repeat (6) @(negedge CLK_I);
    endtask

    task automatic wb_read(input logic adr, output logic [31:0] d);
        STB_I = 1'b1; WE_I = 1'b0; ADR_I = adr;
        @(negedge CLK_I);
        chk("ack_rise", {31'b0, ACK_O}, 32'd1);
        d = DAT_O;
        STB_I = 1'b0;
        @(negedge CLK_I);
        chk("ack_fall", {31'b0, ACK_O}, 32'd0);
    endtask

    task automatic wb_write(input logic adr, input logic [31:0] d);
        STB_I = 1'b1; WE_I = 1'b1; ADR_I = adr; DAT_I = d;
        @(negedge CLK_I);
        chk("wack", {31'b0, ACK_O}, 32'd1);
        STB_I = 1'b0; WE_I = 1'b0; DAT_I = '0;
        @(negedge CLK_I);
    endtask

    initial begin
        RST_In = 1'b0; usartRX = 1'b1;
        STB_I = 1'b0; WE_I = 1'b0; ADR_I = 1'b0; DAT_I = '0;
        repeat (3) @(negedge CLK_I);
        chk("rst_ack",  {31'b0, ACK_O}, 32'd0);
        chk("rst_dat",  DAT_O, 32'd0);
        chk("rst_irq",  {31'b0, rxirq}, 32'd0);
        RST_In = 1'b1;
        repeat (4) @(negedge CLK_I);
        wb_read(1'b1, rd); chk("rst_status", rd, 32'h000);

        // single byte
        send(8'hA5, 1'b1);
        chk("sb_irq", {31'b0, rxirq}, 32'd1);
        wb_read(1'b0, rd); chk("sb_data", rd, 32'h1A5);
        chk("sb_irq0", {31'b0, rxirq}, 32'd0);
        wb_read(1'b0, rd); chk("sb_empty", rd, 32'h000);
        wb_read(1'b1, rd); chk("sb_status", rd, 32'h000);

        // overrun: fifth byte is dropped
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
        wb_read(1'b1, rd); chk("ovr_status", rd, 32'h087);
        for (int i = 1; i <= 4; i++) begin
            wb_read(1'b0, rd); chk("ovr_data", rd, 32'h100 + 32'(i));
        end
        wb_read(1'b1, rd); chk("ovr_sticky", rd, 32'h004);
        wb_write(1'b1, 32'h4);
        wb_read(1'b1, rd); chk("ovr_clr", rd, 32'h000);

        // framing error
        send(8'h3C, 1'b0);
        chk("ferr_irq", {31'b0, rxirq}, 32'd0);
        wb_read(1'b1, rd); chk("ferr_status", rd, 32'h008);
        send(8'h55, 1'b1);
        wb_read(1'b0, rd); chk("ferr_next", rd, 32'h155);
        wb_write(1'b1, 32'h8);
        wb_read(1'b1, rd); chk("ferr_clr", rd, 32'h000);

        // glitch on the line
        usartRX = 1'b0;
        repeat (2) @(negedge CLK_I);
        usartRX = 1'b1;
        repeat (20) @(negedge CLK_I);
        chk("gl_irq", {31'b0, rxirq}, 32'd0);
        wb_read(1'b1, rd); chk("gl_status", rd, 32'h000);

        // two-cycle strobe: one ack, one pop
        send(8'h21, 1'b1); send(8'h22, 1'b1); send(8'h23, 1'b1);
        STB_I = 1'b1; WE_I = 1'b0; ADR_I = 1'b0;
        @(negedge CLK_I);
        chk("s2_ack1", {31'b0, ACK_O}, 32'd1);
        chk("s2_data", DAT_O, 32'h121);
        @(negedge CLK_I);
        chk("s2_ack2", {31'b0, ACK_O}, 32'd0);
        STB_I = 1'b0;
        @(negedge CLK_I);
        wb_read(1'b1, rd); chk("s2_status", rd, 32'h041);

        // read ACK on the same edge as the stop-sample push (P79 after frame start)
        fork
            send(8'h77, 1'b1);
            begin
                repeat (78) @(negedge CLK_I);
                wb_read(1'b0, rd2);
            end
        join
        chk("cc_data", rd2, 32'h122);
        wb_read(1'b1, rd); chk("cc_status", rd, 32'h041);
        wb_read(1'b0, rd); chk("cc_d1", rd, 32'h123);
        wb_read(1'b0, rd); chk("cc_d2", rd, 32'h177);
        wb_read(1'b0, rd); chk("cc_d3", rd, 32'h000);

        // reset during bit 4 with a byte already queued
        send(8'h11, 1'b1);
        wb_read(1'b1, rd); chk("mr_pre", rd, 32'h021);
        send_bits(8'hC3, 1'b1, 5);
        usartRX = 1'b0;           // bit 4 of 0xC3
        repeat (4) @(negedge CLK_I);
        RST_In = 1'b0;
        @(negedge CLK_I);
        chk("mr_ack", {31'b0, ACK_O}, 32'd0);
        chk("mr_dat", DAT_O, 32'd0);
        chk("mr_irq", {31'b0, rxirq}, 32'd0);
        usartRX = 1'b1;
        repeat (2) @(negedge CLK_I);
        RST_In = 1'b1;
        repeat (20) @(negedge CLK_I);
        chk("mr_irq2", {31'b0, rxirq}, 32'd0);
        wb_read(1'b1, rd); chk("mr_status", rd, 32'h000);
        send(8'hC3, 1'b1);
        wb_read(1'b0, rd); chk("mr_next", rd, 32'h1C3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
